read_state: RTL and testbench
=============================

Name: read_state

Overview:
- Single-burst SDRAM read sequencer; the read-direction counterpart of the burst write sequencer.
- Sits under the SDRAM controller top, in parallel with the write and refresh sequencers. The top arbitrates and muxes their Cs_n/Ras_n/Cas_n/We_n/Sa/Ba.
- Sequence: ACTIVATE row → READ column (no auto-precharge) → capture SC_BL beats from Dq after CAS latency → PRECHARGE all → wait tRP → done.
- Sequencing is a linear counter, not an explicit state machine.

Parameters:
- ASIZE, 13, SDRAM address bus width
- BSIZE, 2, bank address width
- DSIZE, 16, data width
- SC_RCD, 3, ACT-to-READ delay in clocks
- SC_CL, 3, CAS latency in clocks; legal values 2 and 3
- SC_BL, 8, burst length; legal values 1, 2, 4, 8
- SC_RP, 3, PRECHARGE-to-idle delay in clocks

Ports:
- Clk  in  1  clock
- Rst_n  in  1  asynchronous active-low reset
- read_en  in  1  level enable from arbiter; low aborts and holds the counter at 0
- baddr_rr  in  BSIZE  bank address; must be stable while read_en is high
- real_raddr_rr  in  ASIZE  row address
- real_caddr_rr  in  ASIZE  column address; only bits [8:0] used
- Dq  in  DSIZE  SDRAM data bus (read side)
- Cs_n, Ras_n, Cas_n, We_n  out  1 each  SDRAM command = {Cs_n,Ras_n,Cas_n,We_n}
- Sa  out  ASIZE  SDRAM address
- Ba  out  BSIZE  SDRAM bank address
- Rd_data  out  DSIZE  captured read beat
- Rd_data_vaild  out  1  Rd_data holds a new beat this cycle
- Rd_beat  out  4  index of the beat on Rd_data, 0..SC_BL-1
- Rdata_done  out  1  high with the last beat
- rd_opt_done  out  1  one-cycle pulse: the read operation is complete

Behaviour:
- Reset is asynchronous, active-low, on Clk rising edge domain. Required Clk and Rst_n: as stated above.
- Command encodings: NOP=0111, ACT=0011, READ=0101, PRE=0010.
- Reset values:
  - Command = NOP
  - Sa = 0, Ba = 0, Rd_data = 0, Rd_beat = 0
  - Rd_data_vaild = 0, rd_opt_done = 0, rd_cnt = 0
- Derived times:
  - ACT_T = 1
  - RD_T = SC_RCD+1
  - CAP_S = RD_T+SC_CL+1
  - PRE_T = CAP_S+SC_BL
  - END_T = PRE_T+SC_RP
- rd_cnt (16 bit) updates on each rising edge:
  - read_en=0 → 0
  - else rd_cnt==END_T → 0
  - else rd_cnt+1
- Command/address registers, loaded on the edge where rd_cnt equals:
  - ACT_T: ACT, Sa=real_raddr_rr, Ba=baddr_rr.
  - RD_T: READ, Sa = {zeros, A10=0, real_caddr_rr[8:0]}, Ba=baddr_rr.
  - PRE_T: PRE, Sa[10]=1 (all banks); other Sa bits and Ba hold.
  - Any other value: NOP; Sa and Ba hold.
- Capture, on an edge with CAP_S ≤ rd_cnt ≤ CAP_S+SC_BL-1:
  - Rd_data ← Dq
  - Rd_beat ← rd_cnt-CAP_S
  - Rd_data_vaild ← 1
- Outside the capture window: Rd_data_vaild ← 0; Rd_data and Rd_beat hold.
- Rdata_done is combinational: (rd_cnt == CAP_S+SC_BL) && read_en. It coincides with the last valid beat.
- rd_opt_done ← (rd_cnt == END_T). It is high for exactly one cycle, while rd_cnt is 0.
- Back-to-back operation: read_en held high restarts the sequence immediately. Period is END_T+1 clocks; the next ACT is loaded at rd_cnt=1.
- Abort (read_en low mid-operation):
  - rd_cnt clears at the next edge; Command becomes NOP the edge after.
  - No further captures; no Rdata_done, no rd_opt_done.
  - Any open row is left open. Issuing PRE is the controller's responsibility.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous).
- Defaults give RD_T=4, CAP_S=8, capture edges at rd_cnt 8..15, PRE_T=16, END_T=19, period 20 clocks.

Test Plan:
- Reset: assert Rst_n=0 mid-burst → Command=0111, Rd_data_vaild=0, rd_opt_done=0, Sa=0, Ba=0 asynchronously; no activity while held.
- Single burst, defaults, row 0x1A5, bank 2, col 0x0F3:
  - ACT with Sa=0x1A5, Ba=2 after the rd_cnt=1 edge.
  - READ with Sa=0x0F3 (A10=0) after the rd_cnt=4 edge.
  - PRE with Sa[10]=1 after the rd_cnt=16 edge.
  - rd_opt_done single pulse after the rd_cnt=19 edge.
- Data capture: SDRAM model drives 0xA000+k for beat k at CL=3 → Rd_data = 0xA000..0xA007 on 8 consecutive Rd_data_vaild cycles, Rd_beat 0..7; Rdata_done only with beat 7.
- Abort: drop read_en at rd_cnt=10 → rd_cnt=0 next edge, Command NOP thereafter, at most one more valid beat, no PRE, no Rdata_done, no rd_opt_done.
- Back-to-back: read_en high for 40 clocks → two complete sequences, ACT commands 20 clocks apart, two rd_opt_done pulses, 16 valid beats total.
- Parameter variant SC_CL=2, SC_BL=4:
  - CAP_S=7, capture edges at rd_cnt 7..10, PRE_T=11, END_T=14.
  - 4 valid beats, rd_opt_done after the rd_cnt=14 edge.

Source files
------------

// File: rtl/read_state.sv
// read_state: single-burst SDRAM read sequencer.
// A free-running linear counter (rd_cnt) drives the whole sequence:
// ACTIVATE row -> READ column (no auto-precharge) -> capture SC_BL beats
// after CAS latency -> PRECHARGE all -> wait tRP -> done pulse.
// Runs in parallel with the write/refresh sequencers; the controller top
// arbitrates between them and muxes their command/address outputs.
module read_state #(
    parameter int ASIZE  = 13,  // SDRAM address bus width
    parameter int BSIZE  = 2,   // bank address width
    parameter int DSIZE  = 16,  // data width
    parameter int SC_RCD = 3,   // ACT-to-READ delay in clocks
    parameter int SC_CL  = 3,   // CAS latency, 2 or 3
    parameter int SC_BL  = 8,   // burst length, 1/2/4/8
    parameter int SC_RP  = 3    // PRECHARGE-to-idle delay in clocks
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             read_en,
    input  logic [BSIZE-1:0] baddr_rr,
    input  logic [ASIZE-1:0] real_raddr_rr,
    input  logic [ASIZE-1:0] real_caddr_rr,
    input  logic [DSIZE-1:0] Dq,
    output logic             Cs_n,
    output logic             Ras_n,
    output logic             Cas_n,
    output logic             We_n,
    output logic [ASIZE-1:0] Sa,
    output logic [BSIZE-1:0] Ba,
    output logic [DSIZE-1:0] Rd_data,
    output logic             Rd_data_vaild,
    output logic [3:0]       Rd_beat,
    output logic             Rdata_done,
    output logic             rd_opt_done
);

    // SDRAM command encodings {Cs_n, Ras_n, Cas_n, We_n}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_PRE = 4'b0010;

    // Sequence milestones, expressed as rd_cnt values.
    // CAP_S adds one clock on top of RD_T+CL because the READ command is
    // registered here and only reaches the device one edge after it is loaded.
    localparam int ACT_T_I  = 1;
    localparam int RD_T_I   = SC_RCD + 1;
    localparam int CAP_S_I  = RD_T_I + SC_CL + 1;
    localparam int CAP_E_I  = CAP_S_I + SC_BL - 1;
    localparam int PRE_T_I  = CAP_S_I + SC_BL;
    localparam int END_T_I  = PRE_T_I + SC_RP;

    localparam logic [15:0] ACT_T  = 16'(ACT_T_I);
    localparam logic [15:0] RD_T   = 16'(RD_T_I);
    localparam logic [15:0] CAP_S  = 16'(CAP_S_I);
    localparam logic [15:0] CAP_E  = 16'(CAP_E_I);
    localparam logic [15:0] PRE_T  = 16'(PRE_T_I);
    localparam logic [15:0] END_T  = 16'(END_T_I);
    // Count value seen right after the last beat has been captured
    localparam logic [15:0] DONE_T = 16'(PRE_T_I);
    // Low nibble of CAP_S; beat index is computed modulo 16, which is exact
    // because the capture window never exceeds 8 beats.
    localparam logic [3:0]  CAP_S_LO = 4'(CAP_S_I);

    // Bit position of the SDRAM auto-precharge / all-banks address line
    localparam int A10 = 10;

    // Returns 1 when the count lies inside the data-capture window
    function automatic logic in_capture_window(input logic [15:0] cnt);
        return (cnt >= CAP_S) && (cnt <= CAP_E);
    endfunction

    // Column address as driven on Sa during READ: bits [8:0] only, A10 low
    // so the bank stays open until the explicit PRECHARGE.
    function automatic logic [ASIZE-1:0] read_col_addr(input logic [ASIZE-1:0] caddr);
        logic [ASIZE-1:0] a;
        a      = {ASIZE{1'b0}};
        a[8:0] = caddr[8:0];
        a[A10] = 1'b0;
        return a;
    endfunction

    // Registered state
    logic [15:0]      rd_cnt_q,   rd_cnt_d;
    logic [3:0]       cmd_q,      cmd_d;
    logic [ASIZE-1:0] sa_q,       sa_d;
    logic [BSIZE-1:0] ba_q,       ba_d;
    logic [DSIZE-1:0] rd_data_q,  rd_data_d;
    logic [3:0]       rd_beat_q,  rd_beat_d;
    logic             rd_vld_q,   rd_vld_d;
    logic             opt_done_q, opt_done_d;

    // Sequence counter: cleared while disabled, wraps after END_T so a held
    // read_en restarts the sequence immediately
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (!read_en) begin
            rd_cnt_d = 16'd0;
        end else if (rd_cnt_q == END_T) begin
            rd_cnt_d = 16'd0;
        end else begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
    end

    // Command and address selection by count milestone; address/bank hold
    // between commands so the controller mux sees stable values
    always_comb begin
        cmd_d = CMD_NOP;
        sa_d  = sa_q;
        ba_d  = ba_q;
        if (rd_cnt_q == ACT_T) begin
            cmd_d = CMD_ACT;
            sa_d  = real_raddr_rr;
            ba_d  = baddr_rr;
        end else if (rd_cnt_q == RD_T) begin
            cmd_d = CMD_RD;
            sa_d  = read_col_addr(real_caddr_rr);
            ba_d  = baddr_rr;
        end else if (rd_cnt_q == PRE_T) begin
            cmd_d     = CMD_PRE;
            sa_d      = sa_q;
            sa_d[A10] = 1'b1;
            ba_d      = ba_q;
        end else begin
            cmd_d = CMD_NOP;
            sa_d  = sa_q;
            ba_d  = ba_q;
        end
    end

    // Read data capture: sample Dq on every edge of the window, tag each
    // beat with its index; outside the window only the valid flag drops
    always_comb begin
        rd_data_d = rd_data_q;
        rd_beat_d = rd_beat_q;
        rd_vld_d  = 1'b0;
        if (in_capture_window(rd_cnt_q)) begin
            rd_data_d = Dq;
            rd_beat_d = rd_cnt_q[3:0] - CAP_S_LO;
            rd_vld_d  = 1'b1;
        end else begin
            rd_data_d = rd_data_q;
            rd_beat_d = rd_beat_q;
            rd_vld_d  = 1'b0;
        end
    end

    // Completion pulse: registered on the wrap edge, so it is high for the
    // single cycle in which rd_cnt has just returned to zero
    always_comb begin
        opt_done_d = 1'b0;
        if (rd_cnt_q == END_T) begin
            opt_done_d = 1'b1;
        end else begin
            opt_done_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset to an idle NOP bus
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_cnt_q   <= 16'd0;
            cmd_q      <= CMD_NOP;
            sa_q       <= {ASIZE{1'b0}};
            ba_q       <= {BSIZE{1'b0}};
            rd_data_q  <= {DSIZE{1'b0}};
            rd_beat_q  <= 4'd0;
            rd_vld_q   <= 1'b0;
            opt_done_q <= 1'b0;
        end else begin
            rd_cnt_q   <= rd_cnt_d;
            cmd_q      <= cmd_d;
            sa_q       <= sa_d;
            ba_q       <= ba_d;
            rd_data_q  <= rd_data_d;
            rd_beat_q  <= rd_beat_d;
            rd_vld_q   <= rd_vld_d;
            opt_done_q <= opt_done_d;
        end
    end

    assign {Cs_n, Ras_n, Cas_n, We_n} = cmd_q;
    assign Sa            = sa_q;
    assign Ba            = ba_q;
    assign Rd_data       = rd_data_q;
    assign Rd_beat       = rd_beat_q;
    assign Rd_data_vaild = rd_vld_q;
    assign rd_opt_done   = opt_done_q;
    // Last-beat flag is combinational so it lines up with the final valid beat
    assign Rdata_done    = (rd_cnt_q == DONE_T) && read_en;

endmodule

// File: tb/tb_read_state.sv
// Testbench for read_state: default instance (CL=3, BL=8) plus a CL=2, BL=4
// variant. A small SDRAM read model drives Dq from the observed READ command;
// expected beats are queued by each scenario and popped by per-DUT monitors.
module tb_read_state;

    localparam int ASIZE = 13;
    localparam int BSIZE = 2;
    localparam int DSIZE = 16;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] PRE = 4'b0010;

    logic             Clk = 1'b0;
    logic             Rst_n;
    logic             read_en0, read_en1;
    logic [BSIZE-1:0] baddr;
    logic [ASIZE-1:0] raddr, caddr;
    logic [DSIZE-1:0] Dq;

    logic             Cs_n0, Ras_n0, Cas_n0, We_n0, vld0, done0, opt0;
    logic [ASIZE-1:0] Sa0;
    logic [BSIZE-1:0] Ba0;
    logic [DSIZE-1:0] Rd_data0;
    logic [3:0]       Rd_beat0;

    logic             Cs_n1, Ras_n1, Cas_n1, We_n1, vld1, done1, opt1;
    logic [ASIZE-1:0] Sa1;
    logic [BSIZE-1:0] Ba1;
    logic [DSIZE-1:0] Rd_data1;
    logic [3:0]       Rd_beat1;

    logic [3:0] cmd0, cmd1;
    assign cmd0 = {Cs_n0, Ras_n0, Cas_n0, We_n0};
    assign cmd1 = {Cs_n1, Ras_n1, Cas_n1, We_n1};

    read_state dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .read_en(read_en0), .baddr_rr(baddr),
        .real_raddr_rr(raddr), .real_caddr_rr(caddr), .Dq(Dq),
        .Cs_n(Cs_n0), .Ras_n(Ras_n0), .Cas_n(Cas_n0), .We_n(We_n0),
        .Sa(Sa0), .Ba(Ba0), .Rd_data(Rd_data0), .Rd_data_vaild(vld0),
        .Rd_beat(Rd_beat0), .Rdata_done(done0), .rd_opt_done(opt0)
    );

    read_state #(.SC_CL(2), .SC_BL(4)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .read_en(read_en1), .baddr_rr(baddr),
        .real_raddr_rr(raddr), .real_caddr_rr(caddr), .Dq(Dq),
        .Cs_n(Cs_n1), .Ras_n(Ras_n1), .Cas_n(Cas_n1), .We_n(We_n1),
        .Sa(Sa1), .Ba(Ba1), .Rd_data(Rd_data1), .Rd_data_vaild(vld1),
        .Rd_beat(Rd_beat1), .Rdata_done(done1), .rd_opt_done(opt1)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_pass = 0;

    // SDRAM read model: READ seen on the bus is latched by the device at the
    // next rising edge; beat k is presented for the edge CL+k after that.
    int cyc       = 0;
    int read_edge = -1000;
    int cur_cl    = 3;
    int cur_bl    = 8;
    int sel       = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        int d;
        if (((sel == 0) ? cmd0 : cmd1) == RD) read_edge <= cyc + 1;
        d = cyc + 1 - read_edge - cur_cl;
        if (d >= 0 && d < cur_bl) Dq <= 16'hA000 + 16'(d);
        else                      Dq <= 16'h5555;
    end

    // Scoreboards: entries are {last, beat, data}
    logic [20:0] q0[$];
    logic [20:0] q1[$];
    int beats0 = 0;
    int beats1 = 0;

    always @(negedge Clk) begin
        logic [20:0] e;
        if (vld0) begin
            beats0++;
            n_chk++;
            if (q0.size() == 0) begin
                $display("FAIL beat0_unexpected: got beat %0d data %h, wanted no beat", Rd_beat0, Rd_data0);
            end else begin
                e = q0.pop_front();
                if ({done0, Rd_beat0, Rd_data0} !== e)
                    $display("FAIL beat0: got done=%b beat=%0d data=%h, wanted done=%b beat=%0d data=%h",
                             done0, Rd_beat0, Rd_data0, e[20], e[19:16], e[15:0]);
                else n_pass++;
            end
        end else begin
            n_chk++;
            if (done0 !== 1'b0) $display("FAIL done0_idle: got %b, wanted 0", done0);
            else n_pass++;
        end
    end

    always @(negedge Clk) begin
        logic [20:0] e;
        if (vld1) begin
            beats1++;
            n_chk++;
            if (q1.size() == 0) begin
                $display("FAIL beat1_unexpected: got beat %0d data %h, wanted no beat", Rd_beat1, Rd_data1);
            end else begin
                e = q1.pop_front();
                if ({done1, Rd_beat1, Rd_data1} !== e)
                    $display("FAIL beat1: got done=%b beat=%0d data=%h, wanted done=%b beat=%0d data=%h",
                             done1, Rd_beat1, Rd_data1, e[20], e[19:16], e[15:0]);
                else n_pass++;
            end
        end else begin
            n_chk++;
            if (done1 !== 1'b0) $display("FAIL done1_idle: got %b, wanted 0", done1);
            else n_pass++;
        end
    end

    task automatic push0(input int n, input int bl);
        for (int k = 0; k < n; k++)
            q0.push_back({(k == bl - 1), k[3:0], 16'hA000 + k[15:0]});
    endtask

    task automatic test_reset;
        Rst_n = 1'b0; read_en0 = 1'b0; read_en1 = 1'b0;
        baddr = '0; raddr = '0; caddr = '0;
        #12;
        n_chk++;
        if ({cmd0, vld0, opt0, Sa0, Ba0, Rd_data0, Rd_beat0} !== {NOP, 1'b0, 1'b0, 13'd0, 2'd0, 16'd0, 4'd0})
            $display("FAIL reset0: got cmd=%b vld=%b opt=%b Sa=%h Ba=%h data=%h beat=%0d, wanted 0111/0/0/0/0/0/0",
                     cmd0, vld0, opt0, Sa0, Ba0, Rd_data0, Rd_beat0);
        else n_pass++;
        n_chk++;
        if ({cmd1, vld1, opt1, Sa1, Ba1} !== {NOP, 1'b0, 1'b0, 13'd0, 2'd0})
            $display("FAIL reset1: got cmd=%b vld=%b opt=%b Sa=%h Ba=%h, wanted 0111/0/0/0/0",
                     cmd1, vld1, opt1, Sa1, Ba1);
        else n_pass++;
        @(negedge Clk); Rst_n = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
    endtask

    // Single burst on defaults; also covers the data-capture scenario
    task automatic test_single;
        logic [3:0] exp_cmd;
        int n;
        sel = 0; cur_cl = 3; cur_bl = 8; beats0 = 0;
        baddr = 2'd2; raddr = 13'h01A5; caddr = 13'h00F3;
        push0(8, 8);
        read_en0 = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(posedge Clk); #1;
            n = k - 1;
            exp_cmd = (n == 1) ? ACT : (n == 4) ? RD : (n == 16) ? PRE : NOP;
            n_chk++;
            if (cmd0 !== exp_cmd) $display("FAIL single_cmd: cnt %0d got %b, wanted %b", n, cmd0, exp_cmd);
            else n_pass++;
            n_chk++;
            if (opt0 !== (n == 19)) $display("FAIL single_opt_done: cnt %0d got %b, wanted %b", n, opt0, (n == 19));
            else n_pass++;
            if (n == 1 || n == 4 || n == 16) begin
                n_chk++;
                if ({Sa0, Ba0} !== {((n == 1) ? 13'h01A5 : (n == 4) ? 13'h00F3 : 13'h04F3), 2'd2})
                    $display("FAIL single_addr: cnt %0d got Sa=%h Ba=%0d", n, Sa0, Ba0);
                else n_pass++;
            end
            if (k == 20) read_en0 = 1'b0;
        end
        repeat (2) @(posedge Clk);
        #1;
        n_chk++;
        if (beats0 !== 8 || q0.size() !== 0)
            $display("FAIL single_beats: got %0d beats (%0d pending), wanted 8 (0)", beats0, q0.size());
        else n_pass++;
    endtask

    task automatic test_abort;
        sel = 0; cur_cl = 3; cur_bl = 8; beats0 = 0;
        baddr = 2'd1; raddr = 13'h0777; caddr = 13'h0012;
        push0(3, 0);
        read_en0 = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        read_en0 = 1'b0;
        for (int k = 11; k <= 35; k++) begin
            @(posedge Clk); #1;
            n_chk++;
            if (cmd0 !== NOP || opt0 !== 1'b0)
                $display("FAIL abort_quiet: edge %0d got cmd=%b opt=%b, wanted 0111/0", k, cmd0, opt0);
            else n_pass++;
        end
        n_chk++;
        if (beats0 !== 3 || q0.size() !== 0)
            $display("FAIL abort_beats: got %0d beats (%0d pending), wanted 3 (0)", beats0, q0.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int act_cnt = 0, done_cnt = 0, first_act = 0, second_act = 0;
        sel = 0; cur_cl = 3; cur_bl = 8; beats0 = 0;
        baddr = 2'd1; raddr = 13'h1FFF; caddr = 13'h1E55;
        push0(8, 8);
        push0(8, 8);
        read_en0 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge Clk); #1;
            if (cmd0 == ACT) begin
                act_cnt++;
                if (act_cnt == 1) first_act = k;
                else second_act = k;
            end
            if (cmd0 == RD) begin
                n_chk++;
                if (Sa0 !== 13'h0055) $display("FAIL b2b_col: got %h, wanted 0055", Sa0);
                else n_pass++;
            end
            if (opt0 === 1'b1) done_cnt++;
            if (k == 40) read_en0 = 1'b0;
        end
        repeat (2) @(posedge Clk);
        #1;
        n_chk++;
        if (act_cnt !== 2 || first_act !== 2 || second_act - first_act !== 20)
            $display("FAIL b2b_act: got %0d ACTs at %0d/%0d, wanted 2 at 2/22", act_cnt, first_act, second_act);
        else n_pass++;
        n_chk++;
        if (done_cnt !== 2) $display("FAIL b2b_opt_done: got %0d pulses, wanted 2", done_cnt);
        else n_pass++;
        n_chk++;
        if (beats0 !== 16 || q0.size() !== 0)
            $display("FAIL b2b_beats: got %0d beats (%0d pending), wanted 16 (0)", beats0, q0.size());
        else n_pass++;
    endtask

    task automatic test_variant;
        logic [3:0] exp_cmd;
        int n;
        sel = 1; cur_cl = 2; cur_bl = 4; beats1 = 0;
        baddr = 2'd3; raddr = 13'h0123; caddr = 13'h01FF;
        for (int k = 0; k < 4; k++)
            q1.push_back({(k == 3), k[3:0], 16'hA000 + k[15:0]});
        read_en1 = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge Clk); #1;
            n = k - 1;
            exp_cmd = (n == 1) ? ACT : (n == 4) ? RD : (n == 11) ? PRE : NOP;
            n_chk++;
            if (cmd1 !== exp_cmd) $display("FAIL var_cmd: cnt %0d got %b, wanted %b", n, cmd1, exp_cmd);
            else n_pass++;
            n_chk++;
            if (opt1 !== (n == 14)) $display("FAIL var_opt_done: cnt %0d got %b, wanted %b", n, opt1, (n == 14));
            else n_pass++;
            if (n == 11) begin
                n_chk++;
                if ({Sa1, Ba1} !== {13'h05FF, 2'd3}) $display("FAIL var_pre_addr: got Sa=%h Ba=%0d, wanted 05FF/3", Sa1, Ba1);
                else n_pass++;
            end
            if (k == 15) read_en1 = 1'b0;
        end
        repeat (2) @(posedge Clk);
        #1;
        n_chk++;
        if (beats1 !== 4 || q1.size() !== 0)
            $display("FAIL var_beats: got %0d beats (%0d pending), wanted 4 (0)", beats1, q1.size());
        else n_pass++;
        sel = 0; cur_cl = 3; cur_bl = 8;
    endtask

    task automatic test_reset_mid;
        sel = 0; cur_cl = 3; cur_bl = 8; beats0 = 0;
        baddr = 2'd2; raddr = 13'h0ABC; caddr = 13'h0044;
        push0(4, 0);
        read_en0 = 1'b1;
        repeat (12) @(posedge Clk);
        @(negedge Clk); #2;
        Rst_n = 1'b0;
        #1;
        n_chk++;
        if ({cmd0, vld0, opt0, Sa0, Ba0, Rd_data0, Rd_beat0} !== {NOP, 1'b0, 1'b0, 13'd0, 2'd0, 16'd0, 4'd0})
            $display("FAIL reset_mid: got cmd=%b vld=%b opt=%b Sa=%h Ba=%h data=%h beat=%0d, wanted 0111/0/0/0/0/0/0",
                     cmd0, vld0, opt0, Sa0, Ba0, Rd_data0, Rd_beat0);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            @(posedge Clk); #1;
            n_chk++;
            if (cmd0 !== NOP || vld0 !== 1'b0 || Sa0 !== 13'd0)
                $display("FAIL reset_hold: got cmd=%b vld=%b Sa=%h, wanted 0111/0/0", cmd0, vld0, Sa0);
            else n_pass++;
        end
        read_en0 = 1'b0;
        @(negedge Clk); Rst_n = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        n_chk++;
        if (beats0 !== 4 || q0.size() !== 0)
            $display("FAIL reset_mid_beats: got %0d beats (%0d pending), wanted 4 (0)", beats0, q0.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_abort();
        test_back_to_back();
        test_variant();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
